pipeline_register_file: RTL and testbench
=========================================

PIPELINE_REGISTER_FILE -- requirements
Module: pipeline_register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits (legal range 8..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter RESET_MODE, default 1: 0 = all registers reset to zero; 1 = register i resets to i, truncated to DATA_WIDTH.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = same-cycle write forwarded to read ports; 0 = no forwarding.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- read_enable  input  1  1 = capture new read data; 0 = hold read outputs (stall).
- read_address_1  input  ADDR_WIDTH  read port 1 address.
- read_address_2  input  ADDR_WIDTH  read port 2 address.
- write_enable  input  1  writeback strobe.
- write_address  input  ADDR_WIDTH  writeback destination.
- write_data_in  input  DATA_WIDTH  writeback data.
- reserve_enable  input  1  marks a destination register pending (instruction issue).
- reserve_address  input  ADDR_WIDTH  register to mark pending.
- read_address_debug  input  ADDR_WIDTH  debug read address.
- data_out_1  output  DATA_WIDTH  registered read data, port 1.
- data_out_2  output  DATA_WIDTH  registered read data, port 2.
- busy_1  output  1  registered pending flag for read_address_1.
- busy_2  output  1  registered pending flag for read_address_2.
- data_out_debug  output  DATA_WIDTH  registered debug read data.
- pending_count  output  ADDR_WIDTH+1  number of registers currently pending.

Function
REQ-006 Register 0 SHALL always read as 0 and never be pending; writes and reserves to address 0 SHALL be ignored.
REQ-007 A write SHALL update r[write_address] on the rising edge when write_enable=1 and write_address!=0.
REQ-008 Read latency SHALL be 1 cycle: when read_enable=1, data_out_n <= value for read_address_n; when read_enable=0, data_out_n and busy_n SHALL hold.
REQ-009 With BYPASS=1, a read SHALL return write_data_in when write_enable=1, write_address==read_address_n and the address is nonzero; otherwise it SHALL return the pre-edge r[read_address_n].
REQ-010 With BYPASS=0, a read SHALL always return the pre-edge register value.
REQ-011 Pending bit p[a] SHALL set on reserve_enable with reserve_address=a, and SHALL clear on a write to a.
REQ-012 If a reserve and a write target the same address in the same cycle, the reserve SHALL win and p[a] SHALL end set.
REQ-013 busy_n SHALL capture p[read_address_n] under read_enable; with BYPASS=1 it SHALL reflect same-cycle write clears but not same-cycle reserves; with BYPASS=0 it SHALL reflect the pre-edge p only.
REQ-014 pending_count SHALL equal the population count of p after every edge, and SHALL never exceed DEPTH-1.
REQ-015 The counter SHALL be +1 on a reserve of a non-pending register, -1 on a write clearing a pending register without a reserve of it, and net of both when they target different addresses.
REQ-016 A reserve of an already-pending register SHALL not change pending_count.
REQ-017 data_out_debug SHALL load pre-edge r[read_address_debug] every cycle, with no bypass and independent of read_enable.

Reset
REQ-018 On reset=0, regardless of clock, the block SHALL immediately apply the following and hold it while reset=0:
- r[i] = 0 (RESET_MODE=0) or i mod 2**DATA_WIDTH (RESET_MODE=1), with r[0]=0 in both modes;
- all p bits cleared and pending_count = 0;
- data_out_1, data_out_2, data_out_debug, busy_1 and busy_2 all 0.
REQ-019 Reset deassertion SHALL be synchronised externally; the first active edge after release SHALL operate normally.
REQ-020 An assertion of reset mid-operation SHALL discard all pending reserves and writes in that cycle.

Verification
REQ-021 Reset, RESET_MODE=1 -> read addresses 0,5,31 -> data_out = 0, 5, 31; pending_count = 0.
REQ-022 Write 0xDEADBEEF to r7 while reading r7, BYPASS=1 -> data_out_1 = 0xDEADBEEF next cycle; with BYPASS=0 -> 7, then 0xDEADBEEF one cycle later; same cycle data_out_debug (addr 7) = 7.
REQ-023 Write 0x1234 to r0 and reserve r0 -> read r0 = 0, busy = 0, pending_count = 0.
REQ-024 Reserve r3, r4, r3 on consecutive cycles -> pending_count 1, 2, 2; write r3 with reserve r3 in the same cycle -> busy for r3 stays 1, count = 2; then write r4 -> count = 1.
REQ-025 read_enable=0 for 3 cycles while r2 is written -> data_out_1 holds its old value; read_enable=1 -> new r2 value.
REQ-026 Reset asserted between edges with 3 registers pending -> outputs 0 and count 0 immediately, without any clock edge.

Source files
------------

// File: rtl/pipeline_register_file_if.sv
// Bundle of the register file's port signals (read, writeback, reserve and
// debug buses). clock and reset stay plain ports on the module.
//
// Handshake semantics: there is no valid/ready pair. Every input is sampled
// on each rising clock edge. read_enable acts as a stall: while it is low the
// read outputs hold. Outputs are registered, and so they are valid one cycle
// after the inputs that produced them.
//
// Modports:
//   master - drives the request signals and observes the read results.
//   slave  - the register file itself.
interface pipeline_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] read_address_1;
    logic [ADDR_WIDTH-1:0] read_address_2;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data_in;
    logic                  reserve_enable;
    logic [ADDR_WIDTH-1:0] reserve_address;
    logic [ADDR_WIDTH-1:0] read_address_debug;
    logic [DATA_WIDTH-1:0] data_out_1;
    logic [DATA_WIDTH-1:0] data_out_2;
    logic                  busy_1;
    logic                  busy_2;
    logic [DATA_WIDTH-1:0] data_out_debug;
    logic [ADDR_WIDTH:0]   pending_count;

    modport master (
        output read_enable, read_address_1, read_address_2,
        output write_enable, write_address, write_data_in,
        output reserve_enable, reserve_address, read_address_debug,
        input  data_out_1, data_out_2, busy_1, busy_2,
        input  data_out_debug, pending_count
    );

    modport slave (
        input  read_enable, read_address_1, read_address_2,
        input  write_enable, write_address, write_data_in,
        input  reserve_enable, reserve_address, read_address_debug,
        output data_out_1, data_out_2, busy_1, busy_2,
        output data_out_debug, pending_count
    );
endinterface

// File: rtl/pipeline_register_file.sv
// Pipeline register file with two registered read ports, one writeback port,
// a pending (scoreboard) bit per register, and a registered debug read port.
// Register 0 is hardwired to zero and is never pending.
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - pipeline_register_file_if.slave, which carries these groups:
//           read         read_enable, read_address_1/2 -> data_out_1/2, busy_1/2
//           writeback    write_enable, write_address, write_data_in
//           reserve      reserve_enable, reserve_address
//           debug        read_address_debug -> data_out_debug
//           scoreboard   pending_count
module pipeline_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_MODE = 1,
    parameter int BYPASS     = 1
) (
    input logic                     clock,
    input logic                     reset,
    pipeline_register_file_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_next;
    logic [ADDR_WIDTH:0]   count_next;

    logic                  write_hit;
    logic                  reserve_hit;
    logic                  write_hit_1;
    logic                  write_hit_2;
    logic                  write_clears_1;
    logic                  write_clears_2;
    logic [DATA_WIDTH-1:0] read_value_1;
    logic [DATA_WIDTH-1:0] read_value_2;
    logic                  read_busy_1;
    logic                  read_busy_2;

    function automatic logic [DATA_WIDTH-1:0] reset_value(input int index);
        if (RESET_MODE == 1) begin
            return DATA_WIDTH'(index);
        end
        return '0;
    endfunction

    always_comb begin
        write_hit      = bus.write_enable && (bus.write_address != '0);
        reserve_hit    = bus.reserve_enable && (bus.reserve_address != '0);
        write_hit_1    = write_hit && (bus.write_address == bus.read_address_1);
        write_hit_2    = write_hit && (bus.write_address == bus.read_address_2);
        // A write only clears the pending bit when no reserve of the same
        // register lands in the same cycle (the reserve wins).
        write_clears_1 = write_hit_1 &&
                         !(reserve_hit && (bus.reserve_address == bus.read_address_1));
        write_clears_2 = write_hit_2 &&
                         !(reserve_hit && (bus.reserve_address == bus.read_address_2));

        read_value_1 = regs[bus.read_address_1];
        read_value_2 = regs[bus.read_address_2];
        read_busy_1  = pending[bus.read_address_1];
        read_busy_2  = pending[bus.read_address_2];
        if (BYPASS != 0) begin
            if (write_hit_1) read_value_1 = bus.write_data_in;
            if (write_hit_2) read_value_2 = bus.write_data_in;
            // Same-cycle clears are forwarded; same-cycle reserves are not.
            if (write_clears_1) read_busy_1 = 1'b0;
            if (write_clears_2) read_busy_2 = 1'b0;
        end

        pending_next = pending;
        if (write_hit)   pending_next[bus.write_address]   = 1'b0;
        if (reserve_hit) pending_next[bus.reserve_address] = 1'b1;
        pending_next[0] = 1'b0;

        // The count is the population count of the next pending vector, so it
        // always agrees with the pending bits and never exceeds DEPTH-1.
        count_next = '0;
        for (int i = 1; i < DEPTH; i++) begin
            count_next = count_next + (ADDR_WIDTH+1)'(pending_next[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == 0) ? '0 : reset_value(i);
            end
        end else if (write_hit) begin
            regs[bus.write_address] <= bus.write_data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending            <= '0;
            bus.pending_count  <= '0;
            bus.data_out_1     <= '0;
            bus.data_out_2     <= '0;
            bus.busy_1         <= 1'b0;
            bus.busy_2         <= 1'b0;
            bus.data_out_debug <= '0;
        end else begin
            pending            <= pending_next;
            bus.pending_count  <= count_next;
            bus.data_out_debug <= regs[bus.read_address_debug];
            if (bus.read_enable) begin
                bus.data_out_1 <= read_value_1;
                bus.data_out_2 <= read_value_2;
                bus.busy_1     <= read_busy_1;
                bus.busy_2     <= read_busy_2;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_register_file.sv
// Self-checking bench for pipeline_register_file. Two instances, one with
// BYPASS=1 and one with BYPASS=0, receive identical stimulus. A reference
// model built from arrays predicts every registered output, and a monitor
// compares both instances one edge later.
module tb_pipeline_register_file;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [DW-1:0] d1_b;
        logic [DW-1:0] d2_b;
        logic          b1_b;
        logic          b2_b;
        logic [DW-1:0] d1_n;
        logic [DW-1:0] d2_n;
        logic          b1_n;
        logic          b2_n;
        logic [DW-1:0] dbg;
        logic [AW:0]   cnt;
    } exp_t;

    logic clock;
    logic reset;

    logic          read_enable;
    logic [AW-1:0] read_address_1;
    logic [AW-1:0] read_address_2;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data_in;
    logic          reserve_enable;
    logic [AW-1:0] reserve_address;
    logic [AW-1:0] read_address_debug;

    pipeline_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();
    pipeline_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_n ();

    assign bus_b.read_enable        = read_enable;
    assign bus_b.read_address_1     = read_address_1;
    assign bus_b.read_address_2     = read_address_2;
    assign bus_b.write_enable       = write_enable;
    assign bus_b.write_address      = write_address;
    assign bus_b.write_data_in      = write_data_in;
    assign bus_b.reserve_enable     = reserve_enable;
    assign bus_b.reserve_address    = reserve_address;
    assign bus_b.read_address_debug = read_address_debug;
    assign bus_n.read_enable        = read_enable;
    assign bus_n.read_address_1     = read_address_1;
    assign bus_n.read_address_2     = read_address_2;
    assign bus_n.write_enable       = write_enable;
    assign bus_n.write_address      = write_address;
    assign bus_n.write_data_in      = write_data_in;
    assign bus_n.reserve_enable     = reserve_enable;
    assign bus_n.reserve_address    = reserve_address;
    assign bus_n.read_address_debug = read_address_debug;

    pipeline_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_MODE(1), .BYPASS(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    pipeline_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_MODE(1), .BYPASS(0)) dut_n (
        .clock (clock),
        .reset (reset),
        .bus   (bus_n)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // Reference model: register contents, pending flags, held read outputs.
    logic [DW-1:0] mr [DEPTH];
    bit            mp [DEPTH];
    exp_t          held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mr[i] = DW'(i);
            mp[i] = 1'b0;
        end
        held = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " d1_b"},  64'(bus_b.data_out_1), 64'd0);
        check({tag, " d2_b"},  64'(bus_b.data_out_2), 64'd0);
        check({tag, " b1_b"},  64'(bus_b.busy_1), 64'd0);
        check({tag, " b2_b"},  64'(bus_b.busy_2), 64'd0);
        check({tag, " dbg_b"}, 64'(bus_b.data_out_debug), 64'd0);
        check({tag, " cnt_b"}, 64'(bus_b.pending_count), 64'd0);
        check({tag, " d1_n"},  64'(bus_n.data_out_1), 64'd0);
        check({tag, " b1_n"},  64'(bus_n.busy_1), 64'd0);
        check({tag, " dbg_n"}, 64'(bus_n.data_out_debug), 64'd0);
        check({tag, " cnt_n"}, 64'(bus_n.pending_count), 64'd0);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: drives one cycle of inputs, predicts
    // the outputs that the next rising edge must produce, and then advances.
    task automatic step(input bit re, input int ra1, input int ra2,
                        input bit we, input int wa, input logic [DW-1:0] wd,
                        input bit rsv, input int rsa, input int rdbg);
        bit wr;
        bit rs;
        int cnt;
        read_enable        = re;
        read_address_1     = AW'(ra1);
        read_address_2     = AW'(ra2);
        write_enable       = we;
        write_address      = AW'(wa);
        write_data_in      = wd;
        reserve_enable     = rsv;
        reserve_address    = AW'(rsa);
        read_address_debug = AW'(rdbg);

        wr = we && (wa != 0);
        rs = rsv && (rsa != 0);
        if (re) begin
            held.d1_b = (wr && wa == ra1) ? wd : mr[ra1];
            held.d2_b = (wr && wa == ra2) ? wd : mr[ra2];
            held.b1_b = mp[ra1] && !(wr && wa == ra1 && !(rs && rsa == ra1));
            held.b2_b = mp[ra2] && !(wr && wa == ra2 && !(rs && rsa == ra2));
            held.d1_n = mr[ra1];
            held.d2_n = mr[ra2];
            held.b1_n = mp[ra1];
            held.b2_n = mp[ra2];
        end
        held.dbg = mr[rdbg];
        if (wr) begin
            mr[wa] = wd;
            mp[wa] = 1'b0;
        end
        if (rs) mp[rsa] = 1'b1;
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) cnt += int'(mp[i]);
        held.cnt = (AW+1)'(cnt);
        exp_q.push_back(held);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data_out_1 bypass",   64'(bus_b.data_out_1), 64'(e.d1_b));
                check("data_out_2 bypass",   64'(bus_b.data_out_2), 64'(e.d2_b));
                check("busy_1 bypass",       64'(bus_b.busy_1), 64'(e.b1_b));
                check("busy_2 bypass",       64'(bus_b.busy_2), 64'(e.b2_b));
                check("debug bypass",        64'(bus_b.data_out_debug), 64'(e.dbg));
                check("count bypass",        64'(bus_b.pending_count), 64'(e.cnt));
                check("data_out_1 nobypass", 64'(bus_n.data_out_1), 64'(e.d1_n));
                check("data_out_2 nobypass", 64'(bus_n.data_out_2), 64'(e.d2_n));
                check("busy_1 nobypass",     64'(bus_n.busy_1), 64'(e.b1_n));
                check("busy_2 nobypass",     64'(bus_n.busy_2), 64'(e.b2_n));
                check("debug nobypass",      64'(bus_n.data_out_debug), 64'(e.dbg));
                check("count nobypass",      64'(bus_n.pending_count), 64'(e.cnt));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cycles;
        read_enable        = 1'b0;
        read_address_1     = '0;
        read_address_2     = '0;
        write_enable       = 1'b0;
        write_address      = '0;
        write_data_in      = '0;
        reserve_enable     = 1'b0;
        reserve_address    = '0;
        read_address_debug = '0;
        reset              = 1'b0;
        model_reset();
        #3;
        check_all_zero("power-on reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Reset values of registers 0, 5 and 31.
        step(1, 0, 5, 0, 0, '0, 0, 0, 31);
        step(1, 31, 0, 0, 0, '0, 0, 0, 5);

        // Write r7 while reading it; the debug port sees the old value.
        step(1, 7, 7, 1, 7, 32'hDEADBEEF, 0, 0, 7);
        step(1, 7, 3, 0, 0, '0, 0, 0, 7);

        // Register 0 ignores writes and reserves.
        step(1, 0, 0, 1, 0, 32'h1234, 1, 0, 0);
        step(1, 0, 0, 0, 0, '0, 0, 0, 0);

        // Reserve r3, r4, r3; write and reserve r3 together; then write r4.
        step(1, 3, 4, 0, 0, '0, 1, 3, 3);
        step(1, 3, 4, 0, 0, '0, 1, 4, 4);
        step(1, 3, 4, 0, 0, '0, 1, 3, 3);
        step(1, 3, 4, 1, 3, 32'h55, 1, 3, 3);
        step(1, 3, 4, 1, 4, 32'h66, 0, 0, 4);
        step(1, 3, 4, 0, 0, '0, 0, 0, 3);

        // Stall for three cycles while r2 is written, then resume.
        step(1, 2, 2, 0, 0, '0, 0, 0, 2);
        step(0, 2, 2, 1, 2, 32'hA1, 0, 0, 2);
        step(0, 2, 2, 1, 2, 32'hA2, 1, 2, 2);
        step(0, 2, 2, 1, 2, 32'hA3, 0, 0, 2);
        step(1, 2, 2, 0, 0, '0, 0, 0, 2);

        // Fill every pending bit, then reserve an already-pending register.
        for (int a = 1; a < DEPTH; a++) step(1, a, 0, 0, 0, '0, 1, a, a);
        step(1, 31, 1, 0, 0, '0, 1, 31, 0);
        for (int a = 1; a < DEPTH; a++) step(1, a, a, 1, a, DW'($urandom), 0, 0, a);

        // Reset between edges with three registers pending and a write and
        // reserve presented in the same cycle.
        step(1, 10, 11, 0, 0, '0, 1, 10, 0);
        step(1, 10, 11, 0, 0, '0, 1, 11, 0);
        step(1, 10, 12, 0, 0, '0, 1, 12, 0);
        write_enable    = 1'b1;
        write_address   = AW'(3);
        write_data_in   = 32'hBAD0BAD0;
        reserve_enable  = 1'b1;
        reserve_address = AW'(9);
        #1;
        reset = 1'b0;
        #2;
        check_all_zero("mid-cycle reset");
        model_reset();
        @(negedge clock);
        write_enable   = 1'b0;
        reserve_enable = 1'b0;
        reset          = 1'b1;
        step(1, 3, 9, 0, 0, '0, 0, 0, 10);
        step(1, 10, 12, 0, 0, '0, 0, 0, 3);

        // Randomised traffic, biased toward low addresses to force collisions.
        for (int n = 0; n < 600; n++) begin
            int ra1, ra2, wa, rsa, rdbg;
            ra1  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            ra2  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            wa   = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            rsa  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            rdbg = $urandom_range(0, 31);
            step($urandom_range(0, 3) != 0, ra1, ra2,
                 $urandom_range(0, 1) != 0, wa, DW'($urandom),
                 $urandom_range(0, 2) != 0, rsa, rdbg);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            idle();
            wait_cycles++;
        end
        // Let the monitor consume the trailing idle cycles.
        @(posedge clock);
        #2;
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
